// File: rtl/onchip_mem_test_master.sv
// Power-on memory self-test master: writes a Galois-LFSR pattern over a word range of an
// Avalon-MM on-chip RAM, reads it back and reports pass/fail, error count and first bad address.
module onchip_mem_test_master #(
  parameter int ADDR_W       = 15,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [READ_LATENCY-1:0] LAST_STAGE = READ_LATENCY'(1) << (READ_LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t state, state_next;

  logic [ADDR_W-1:0] base_q, cur_addr;
  logic [CNT_W-1:0]  count_q, beat_idx;
  logic [31:0]       seed_q, seed_eff, lfsr;
  logic              beat_ok, last_beat, push, drain_empty, mismatch;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [31:0]             pipe_exp  [READ_LATENCY];
  logic [ADDR_W-1:0]       pipe_addr [READ_LATENCY];

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  assign seed_eff    = (seed == '0) ? 32'h1 : seed;
  assign beat_ok     = avm_chipselect && !avm_waitrequest;
  assign last_beat   = (beat_idx == count_q - CNT_W'(1));
  assign push        = avm_read && beat_ok;
  // The drain may end on the same edge as the final compare: only the last stage may still be valid.
  assign drain_empty = ((pipe_vld & ~LAST_STAGE) == '0);
  assign mismatch    = pipe_vld[READ_LATENCY-1] && (avm_readdata != pipe_exp[READ_LATENCY-1]);

  assign avm_byteenable = 4'hF;
  assign avm_chipselect = avm_write || avm_read;
  assign avm_address    = cur_addr;
  assign avm_writedata  = lfsr;
  assign pass           = done && (error_count == '0);

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    avm_write  = 1'b0;
    avm_read   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = (word_count == '0) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        avm_write = 1'b1;
        if (!avm_waitrequest && last_beat) state_next = S_READ;
      end
      S_READ: begin
        busy     = 1'b1;
        avm_read = 1'b1;
        if (!avm_waitrequest && last_beat) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_empty) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = (word_count == '0) ? S_DONE : S_WRITE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q         <= '0;
      count_q        <= '0;
      seed_q         <= '0;
      cur_addr       <= '0;
      lfsr           <= '0;
      beat_idx       <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
    end else begin
      if (mismatch) begin
        if (error_count != '1) error_count <= error_count + CNT_W'(1);
        if (error_count == '0) first_err_addr <= pipe_addr[READ_LATENCY-1];
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q         <= base_addr;
            count_q        <= word_count;
            seed_q         <= seed_eff;
            cur_addr       <= base_addr;
            lfsr           <= seed_eff;
            beat_idx       <= '0;
            error_count    <= '0;
            first_err_addr <= '0;
          end
        end
        S_WRITE, S_READ: begin
          // Address, data and LFSR hold while stalled; the last beat rewinds for the next phase.
          if (beat_ok) begin
            if (last_beat) begin
              cur_addr <= base_q;
              lfsr     <= seed_q;
              beat_idx <= '0;
            end else begin
              cur_addr <= cur_addr + ADDR_W'(1);
              lfsr     <= lfsr_step(lfsr);
              beat_idx <= beat_idx + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= push;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // NOTE: the payload stages have no reset; they are only looked at when their valid bit is set.
  always_ff @(posedge clk) begin
    pipe_exp[0]  <= lfsr;
    pipe_addr[0] <= cur_addr;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_exp[i]  <= pipe_exp[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Self-checking bench: two masters (read latency 1 and 3) share stimulus; each drives its own
// behavioural RAM, and a queue-based pattern model predicts beats, results and done latency.
module tb_onchip_mem_test_master;

  localparam int ADDR_W = 15;
  localparam int CNT_W  = 16;
  localparam int RL0    = 1;
  localparam int RL1    = 3;

  logic clk = 1'b0;
  logic reset, start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic [31:0]       seed;
  logic              avm_waitrequest;

  logic              busy [2];
  logic              done [2];
  logic              pass [2];
  logic [CNT_W-1:0]  error_count [2];
  logic [ADDR_W-1:0] first_err_addr [2];
  logic [ADDR_W-1:0] avm_address [2];
  logic [3:0]        avm_byteenable [2];
  logic              avm_chipselect [2];
  logic              avm_write [2];
  logic              avm_read [2];
  logic [31:0]       avm_writedata [2];
  logic [31:0]       avm_readdata [2];

  onchip_mem_test_master #(.ADDR_W(ADDR_W), .READ_LATENCY(RL0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .seed(seed), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .error_count(error_count[0]),
    .first_err_addr(first_err_addr[0]), .avm_address(avm_address[0]),
    .avm_byteenable(avm_byteenable[0]), .avm_chipselect(avm_chipselect[0]),
    .avm_write(avm_write[0]), .avm_read(avm_read[0]), .avm_writedata(avm_writedata[0]),
    .avm_readdata(avm_readdata[0]), .avm_waitrequest(avm_waitrequest)
  );

  onchip_mem_test_master #(.ADDR_W(ADDR_W), .READ_LATENCY(RL1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .seed(seed), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .error_count(error_count[1]),
    .first_err_addr(first_err_addr[1]), .avm_address(avm_address[1]),
    .avm_byteenable(avm_byteenable[1]), .avm_chipselect(avm_chipselect[1]),
    .avm_write(avm_write[1]), .avm_read(avm_read[1]), .avm_writedata(avm_writedata[1]),
    .avm_readdata(avm_readdata[1]), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0]       mem [2][1 << ADDR_W];
  logic [31:0]       pend [2];
  logic [31:0]       rpipe [2][3];
  logic [31:0]       exp_data [$];
  logic [ADDR_W-1:0] t_base;
  int                t_count;
  int                wr_seen [2];
  int                rd_seen [2];
  bit                expect_beats;
  bit                wait_en;
  bit                flip_en;
  logic [ADDR_W-1:0] flip_addr;

  function automatic int rl(input int d);
    return (d == 0) ? RL0 : RL1;
  endfunction

  function automatic string tg(input int d, input string s);
    return $sformatf("rl%0d %s", rl(d), s);
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave side: new waitrequest per cycle and read data delivered rl(d) clocks after acceptance.
  always @(posedge clk) begin
    #1;
    avm_waitrequest = wait_en ? ($urandom_range(0, 1) == 1) : 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 2; i > 0; i--) rpipe[d][i] = rpipe[d][i-1];
      rpipe[d][0] = pend[d];
      pend[d] = $urandom();
      avm_readdata[d] = rpipe[d][rl(d)-1];
    end
  end

  // Mid-cycle look at each bus: the beat shown now is accepted at the next rising edge.
  task automatic observe();
    for (int d = 0; d < 2; d++) begin
      check(tg(d, "strobe_excl"), avm_write[d] & avm_read[d], 1'b0);
      check(tg(d, "chipselect"), avm_chipselect[d], avm_write[d] | avm_read[d]);
      check(tg(d, "byteenable"), avm_byteenable[d], 4'hF);
      if (avm_chipselect[d] && !avm_waitrequest && avm_write[d]) begin
        check(tg(d, "wr_index"), (wr_seen[d] < t_count) && expect_beats, 1'b1);
        if (wr_seen[d] < t_count) begin
          check(tg(d, "wr_addr"), avm_address[d], ADDR_W'(t_base + wr_seen[d]));
          check(tg(d, "wr_data"), avm_writedata[d], exp_data[wr_seen[d]]);
          wr_seen[d]++;
        end
        mem[d][avm_address[d]] = avm_writedata[d] ^
          ((flip_en && avm_address[d] == flip_addr) ? 32'h0000_0100 : 32'h0);
      end
      if (avm_chipselect[d] && !avm_waitrequest && avm_read[d]) begin
        check(tg(d, "rd_index"), (rd_seen[d] < t_count) && expect_beats, 1'b1);
        check(tg(d, "rd_after_wr"), wr_seen[d], t_count);
        if (rd_seen[d] < t_count) begin
          check(tg(d, "rd_addr"), avm_address[d], ADDR_W'(t_base + rd_seen[d]));
          rd_seen[d]++;
        end
        pend[d] = mem[d][avm_address[d]];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
  endtask

  task automatic check_idle(input string name);
    for (int d = 0; d < 2; d++) begin
      check(tg(d, {name, " busy"}), busy[d], 1'b0);
      check(tg(d, {name, " done"}), done[d], 1'b0);
      check(tg(d, {name, " pass"}), pass[d], 1'b0);
      check(tg(d, {name, " error_count"}), error_count[d], '0);
      check(tg(d, {name, " first_err_addr"}), first_err_addr[d], '0);
      check(tg(d, {name, " address"}), avm_address[d], '0);
      check(tg(d, {name, " writedata"}), avm_writedata[d], '0);
      check(tg(d, {name, " strobes"}), {avm_chipselect[d], avm_write[d], avm_read[d]}, 3'b000);
    end
  endtask

  task automatic run_test(input string name, input logic [ADDR_W-1:0] base, input int count,
                          input logic [31:0] sd, input bit waits, input bit flip,
                          input logic [ADDR_W-1:0] faddr, input int glitch_at, input int reset_at);
    logic [31:0]       s;
    int                exp_err;
    logic [ADDR_W-1:0] exp_first;
    int                pulse_cyc, budget, exp_lat;
    int                done_cyc [2];
    bit                glitched;

    exp_data.delete();
    s = (sd == 32'h0) ? 32'h1 : sd;
    exp_err = 0;
    exp_first = '0;
    for (int i = 0; i < count; i++) begin
      exp_data.push_back(s);
      s = lfsr_next(s);
      if (flip && ADDR_W'(base + i) == faddr) begin
        exp_err = 1;
        exp_first = faddr;
      end
    end
    t_base = base;
    t_count = count;
    wr_seen = '{0, 0};
    rd_seen = '{0, 0};
    flip_en = flip;
    flip_addr = faddr;
    wait_en = waits;
    expect_beats = 1'b1;
    done_cyc = '{-1, -1};
    glitched = 1'b0;

    step();
    base_addr = base;
    word_count = CNT_W'(count);
    seed = sd;
    start = 1'b1;
    pulse_cyc = cyc;
    step();
    start = 1'b0;
    budget = 4 * count + 64;
    for (int k = 0; k < budget; k++) begin
      for (int d = 0; d < 2; d++)
        if (done[d] && done_cyc[d] < 0) done_cyc[d] = cyc;
      if (done_cyc[0] >= 0 && done_cyc[1] >= 0) break;
      if (glitch_at >= 0 && !glitched && rd_seen[0] == glitch_at) begin
        glitched = 1'b1;
        start = 1'b1;
        base_addr = ~base;
        word_count = CNT_W'(3);
        seed = ~sd;
      end
      if (reset_at >= 0 && rd_seen[0] == reset_at) begin
        reset = 1'b1;
        step();
        check_idle({name, " after_reset"});
        reset = 1'b0;
        expect_beats = 1'b0;
        repeat (6) begin
          step();
          for (int d = 0; d < 2; d++) begin
            check(tg(d, {name, " post_reset error_count"}), error_count[d], '0);
            check(tg(d, {name, " post_reset busy"}), {busy[d], done[d]}, 2'b00);
          end
        end
        return;
      end
      step();
      start = 1'b0;
    end

    for (int d = 0; d < 2; d++) begin
      check(tg(d, {name, " done_reached"}), done_cyc[d] >= 0, 1'b1);
      exp_lat = (count == 0) ? 1 : 2 * count + rl(d) + 1;
      if (!waits) check(tg(d, {name, " done_latency"}), done_cyc[d] - pulse_cyc, exp_lat);
      check(tg(d, {name, " error_count"}), error_count[d], CNT_W'(exp_err));
      check(tg(d, {name, " first_err_addr"}), first_err_addr[d], exp_first);
      check(tg(d, {name, " pass"}), pass[d], exp_err == 0);
      check(tg(d, {name, " writes"}), wr_seen[d], count);
      check(tg(d, {name, " reads"}), rd_seen[d], count);
      check(tg(d, {name, " busy_at_done"}), busy[d], 1'b0);
      check(tg(d, {name, " strobes_at_done"}), avm_chipselect[d], 1'b0);
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] b;
    int                n;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    seed = '0;
    wait_en = 1'b0;
    flip_en = 1'b0;
    flip_addr = '0;
    expect_beats = 1'b0;
    t_base = '0;
    t_count = 0;
    wr_seen = '{0, 0};
    rd_seen = '{0, 0};
    avm_waitrequest = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pend[d] = '0;
      avm_readdata[d] = '0;
      for (int i = 0; i < 3; i++) rpipe[d][i] = '0;
    end

    repeat (3) step();
    check_idle("reset");
    reset = 1'b0;
    step();

    run_test("basic", 15'd0, 8, 32'h1, 1'b0, 1'b0, 15'd0, -1, -1);
    run_test("flip5", 15'd0, 8, 32'h1, 1'b0, 1'b1, 15'd5, -1, -1);
    run_test("wrap", 15'd32766, 4, 32'hACE1_2345, 1'b0, 1'b0, 15'd0, -1, -1);
    run_test("seed0", 15'd300, 8, 32'h0, 1'b0, 1'b0, 15'd0, -1, -1);
    run_test("waits", ADDR_W'($urandom_range(0, 32767)), 64, $urandom(), 1'b1, 1'b0, 15'd0, -1, -1);
    run_test("glitch", 15'd1000, 16, 32'h1234_5678, 1'b0, 1'b0, 15'd0, 4, -1);
    run_test("midreset", 15'd200, 16, 32'hCAFE_F00D, 1'b0, 1'b1, 15'd202, -1, 3);
    run_test("zero", 15'd77, 0, 32'h5, 1'b0, 1'b0, 15'd0, -1, -1);

    for (int t = 0; t < 4; t++) begin
      b = ADDR_W'($urandom_range(0, 32767));
      n = $urandom_range(1, 40);
      run_test($sformatf("rand%0d", t), b, n, $urandom(), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 1) == 1), ADDR_W'(b + $urandom_range(0, n + 2)), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
